// File: rtl/sliced_adder.sv
`default_nettype none
// ============================================================================
// Module      : sliced_adder
// Description : Multi-cycle add/subtract unit. The operands are processed
//               SLICE bits per clock, from the LSB slice up to the MSB slice,
//               and the carry is held in a register between slices. This keeps
//               the carry path one slice long at the cost of NSLICE cycles of
//               latency.
//
//               Subtract is a + ~b + ~cin. cout is the raw carry out of the
//               MSB, so for a subtract cout=1 means "no borrow".
//
// Parameters  : WIDTH - operand/result width (integer multiple of SLICE)
//               SLICE - bits added per clock (SLICE == WIDTH is legal)
//
// Ports       : clk    - clock, rising edge
//               rst_n  - asynchronous active-low reset
//               start  - launch request, accepted when start && ready
//               ready  - idle and able to accept (== !busy)
//               busy   - operation in progress
//               a, b   - operands, sampled at accept
//               cin    - carry-in (add) / borrow-in (sub), sampled at accept
//               sub    - 0: a+b+cin, 1: a-b-cin, sampled at accept
//               sum    - registered result, held until the next completion
//               cout   - registered raw carry out of the MSB
//               done   - one-cycle pulse, result valid
//               ovf    - signed overflow flag (SLICED_ADDER_FLAGS_EN only)
//               zero   - result == 0 flag   (SLICED_ADDER_FLAGS_EN only)
//
// Build option: define SLICED_ADDER_FLAGS_EN to add the ovf/zero outputs.
//
// Revision    : 1.0 - initial release
// ============================================================================
module sliced_adder #(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             ready,
  output logic             busy,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
`ifdef SLICED_ADDER_FLAGS_EN
  output logic             ovf,
  output logic             zero,
`endif
  output logic             done
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [CNT_W-1:0] LAST_SLICE = CNT_W'(NSLICE - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state;
  state_t           state_next;

  logic             accept;
  logic             last;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;       // already inverted for subtract
  logic             carry;
  logic [WIDTH-1:0] acc;        // partial result, never visible on sum
  logic [WIDTH-1:0] acc_next;   // acc with the current slice written in
  logic [SLICE-1:0] a_sl [NSLICE];
  logic [SLICE-1:0] b_sl [NSLICE];
  logic [SLICE:0]   slice_sum;  // MSB is the carry out of this slice

  assign ready  = !busy;
  assign accept = start && ready;
  assign last   = (cnt == LAST_SLICE);

  // --------------------------------------------------------------------------
  // Slice extraction and accumulator merge
  // --------------------------------------------------------------------------
  for (genvar i = 0; i < NSLICE; i++) begin : g_slice
    assign a_sl[i] = op_a[i*SLICE +: SLICE];
    assign b_sl[i] = op_b[i*SLICE +: SLICE];
    assign acc_next[i*SLICE +: SLICE] =
        (cnt == CNT_W'(i)) ? slice_sum[SLICE-1:0] : acc[i*SLICE +: SLICE];
  end

  assign slice_sum = {1'b0, a_sl[cnt]} + {1'b0, b_sl[cnt]} + (SLICE+1)'(carry);

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (last) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a  <= '0;
      op_b  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      acc   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        op_a  <= a;
        op_b  <= sub ? ~b : b;
        // Subtract needs carry-in = 1 - borrow_in, i.e. the inverted cin.
        carry <= cin ^ sub;
        cnt   <= '0;
      end else if (state == RUN) begin
        acc   <= acc_next;
        carry <= slice_sum[SLICE];
        cnt   <= cnt + CNT_W'(1);
        if (last) begin
          // acc_next already holds the top slice, so the whole result is
          // published in one edge and sum is never seen half-updated.
          sum  <= acc_next;
          cout <= slice_sum[SLICE];
          done <= 1'b1;
          cnt  <= '0;
        end
      end
    end
  end

`ifdef SLICED_ADDER_FLAGS_EN
  // Carry into the MSB is recovered from the MSB sum bit: s = a ^ b ^ c_in.
  logic ovf_next;
  assign ovf_next = op_a[WIDTH-1] ^ op_b[WIDTH-1] ^ acc_next[WIDTH-1] ^ slice_sum[SLICE];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf  <= 1'b0;
      zero <= 1'b0;
    end else if (!accept && (state == RUN) && last) begin
      ovf  <= ovf_next;
      zero <= (acc_next == '0);
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_sliced_adder.sv
`default_nettype none
// ============================================================================
// Module      : tb_sliced_adder
// Description : Self-checking bench for sliced_adder (WIDTH=32, SLICE=8).
//               Expected results come from a plain-arithmetic reference model.
//               Define SLICED_ADDER_FLAGS_EN to also check ovf/zero.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sliced_adder;

  localparam int WIDTH  = 32;
  localparam int SLICE  = 8;
  localparam int NSLICE = WIDTH / SLICE;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic             ready;
  logic             busy;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             done;
`ifdef SLICED_ADDER_FLAGS_EN
  logic             ovf;
  logic             zero;
`endif

  int total;
  int bad;

  sliced_adder #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .ready (ready),
    .busy  (busy),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .sub   (sub),
    .sum   (sum),
    .cout  (cout),
`ifdef SLICED_ADDER_FLAGS_EN
    .ovf   (ovf),
    .zero  (zero),
`endif
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference: true integer arithmetic, then reduce modulo 2^WIDTH.
  function automatic void model(input logic [31:0] ta, input logic [31:0] tb_v,
                                input logic tcin, input logic tsub,
                                output logic [31:0] es, output logic ec,
                                output logic eo, output logic ez);
    longint ua, ub, r, sa, sb, sr;
    ua = longint'(ta);
    ub = longint'(tb_v);
    sa = longint'($signed(ta));
    sb = longint'($signed(tb_v));
    if (!tsub) begin
      r  = ua + ub + longint'(tcin);
      sr = sa + sb + longint'(tcin);
      ec = (r >= 64'sh1_0000_0000);
    end else begin
      r  = ua - ub - longint'(tcin);
      sr = sa - sb - longint'(tcin);
      ec = (r >= 0);                  // carry out = no borrow
    end
    es = r[31:0];
    eo = (sr > 64'sh7FFF_FFFF) || (sr < -64'sh8000_0000);
    ez = (es == 32'h0);
  endfunction

  // One full operation with latency, busy, hold and ignored-start checks.
  task automatic do_op(input logic [31:0] ta, input logic [31:0] tb_v,
                       input logic tcin, input logic tsub, input string tag);
    logic [31:0] es, prev_sum;
    logic        ec, eo, ez, prev_cout;
    int          n;
    model(ta, tb_v, tcin, tsub, es, ec, eo, ez);
    @(negedge clk);
    chk({tag, ":ready"}, 64'(ready), 64'd1);
    a = ta; b = tb_v; cin = tcin; sub = tsub; start = 1'b1;
    prev_sum  = sum;
    prev_cout = cout;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = $urandom; b = $urandom; cin = 1'($urandom); sub = 1'($urandom);
    n = 0;
    while (n < 20) begin
      @(negedge clk);
      n++;
      if (done) break;
      chk({tag, ":busy"}, 64'(busy), 64'd1);
      chk({tag, ":hold"}, {31'd0, prev_cout, prev_sum}, {31'd0, cout, sum});
      // A start request while busy must be ignored.
      if (n == 2) start = 1'b1;
      if (n == 3) start = 1'b0;
    end
    chk({tag, ":edges_to_done"}, 64'(n - 1), 64'(NSLICE));
    chk({tag, ":sum"}, 64'(sum), 64'(es));
    chk({tag, ":cout"}, 64'(cout), 64'(ec));
    chk({tag, ":ready_in_done"}, 64'(ready), 64'd1);
`ifdef SLICED_ADDER_FLAGS_EN
    chk({tag, ":ovf"}, 64'(ovf), 64'(eo));
    chk({tag, ":zero"}, 64'(zero), 64'(ez));
`endif
    @(negedge clk);
    chk({tag, ":done_one_cycle"}, 64'(done), 64'd0);
    chk({tag, ":sum_held"}, 64'(sum), 64'(es));
  endtask

  initial begin
    int          d1_k, d2_k, seen;
    logic [31:0] d1_s, d2_s;
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    start = 1'b0;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst:sum", 64'(sum), 64'd0);
    chk("rst:cout", 64'(cout), 64'd0);
    chk("rst:done", 64'(done), 64'd0);
    chk("rst:busy", 64'(busy), 64'd0);
    chk("rst:ready", 64'(ready), 64'd1);
    rst_n = 1'b1;

    do_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, "ripple");
    do_op(32'd5, 32'd7, 1'b0, 1'b1, "sub5m7");
    do_op(32'd7, 32'd5, 1'b0, 1'b1, "sub7m5");
    do_op(32'h0000_FFFF, 32'h0, 1'b1, 1'b0, "xslice");
    do_op(32'd0, 32'd0, 1'b1, 1'b1, "sub_borrow_in");
    do_op(32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0, "ovf_add");
    do_op(32'd5, 32'd5, 1'b0, 1'b1, "zero_sub");
    for (int i = 0; i < 16; i++) begin
      do_op($urandom, $urandom, 1'($urandom), 1'($urandom), $sformatf("rand%0d", i));
    end

    // Back-to-back with start held high. Cycle k = k-th falling edge after
    // the first accept. First done at k=5; the second op is accepted at the
    // end of that done cycle and completes NSLICE edges later (k=10).
    @(negedge clk);
    a = 32'd1; b = 32'd2; cin = 1'b0; sub = 1'b0; start = 1'b1;
    @(posedge clk);
    d1_k = 0; d2_k = 0; d1_s = '0; d2_s = '0;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      if (done && d1_k == 0) begin d1_k = k; d1_s = sum; end
      else if (done && d2_k == 0) begin d2_k = k; d2_s = sum; end
      if (k == 1) begin a = 32'd99; b = 32'd77; end
      if (k == 5) begin a = 32'd3;  b = 32'd4;  end
      if (k == 6) begin a = 32'd55; b = 32'd66; cin = 1'b1; end
      if (k == 10) start = 1'b0;
    end
    chk("b2b:first_done_cycle", 64'(d1_k), 64'(NSLICE + 1));
    chk("b2b:first_sum", 64'(d1_s), 64'd3);
    chk("b2b:second_done_cycle", 64'(d2_k), 64'(2 * (NSLICE + 1)));
    chk("b2b:second_sum", 64'(d2_s), 64'd7);
    cin = 1'b0;

    // Reset two edges into an operation.
    @(negedge clk);
    a = 32'h1234_5678; b = 32'h1111_1111; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("abort:sum", 64'(sum), 64'd0);
    chk("abort:cout", 64'(cout), 64'd0);
    chk("abort:ready", 64'(ready), 64'd1);
    chk("abort:busy", 64'(busy), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (done) seen++;
    end
    chk("abort:no_done", 64'(seen), 64'd0);
    do_op(32'd10, 32'd20, 1'b0, 1'b0, "after_abort");
    chk("after_abort:sum30", 64'(sum), 64'd30);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
